fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have port PC, input, 32, the current fetch address held by the IFU.
REQ-005 SHALL have port im_ready, input, 1; high means instruction memory returns a valid word for PC this cycle.
REQ-006 SHALL have port hazard_stall, input, 1, the decode-stage interlock request.
REQ-007 SHALL have port redir_valid, input, 1, a branch-taken/j/jal/jr redirect from D.
REQ-008 SHALL have port redir_target, input, 32, the redirect address, 4-byte aligned.
REQ-009 SHALL have port halt_req, input, 1, a single-cycle request to stop fetching.
REQ-010 SHALL have port resume, input, 1, a single-cycle request to restart fetching.
REQ-011 SHALL have port next_PC, output, 32, the address the IFU loads at the next edge.
REQ-012 SHALL have port stall, output, 1; high freezes the IFU PC register.
REQ-013 SHALL have port F_valid, output, 1; high means the fetched instruction may enter F/D.
REQ-014 SHALL have port fetch_count, output, 16, the number of PC advances, wrapping.
REQ-015 SHALL have port state, output, 2: BOOT=0, RUN=1, WAIT=2, HALT=3.

Function
REQ-016 The FSM SHALL be: BOOT->RUN unconditionally; RUN->WAIT when im_ready=0; WAIT->RUN when im_ready=1; RUN/WAIT->HALT on halt_req; HALT->RUN on resume with halt_req=0.
REQ-017 The stall priority SHALL be: reset > HALT > hazard_stall > !im_ready; stall=1 in HALT, when hazard_stall=1, or when im_ready=0.
REQ-018 In BOOT, the outputs SHALL be stall=0, next_PC=RESET_PC, F_valid=0, and fetch_count SHALL NOT change.
REQ-019 Next-PC priority when not stalled SHALL be: redir_valid -> redir_target; else pend_valid -> pend_target; else PC+4.
REQ-020 PC+4 SHALL be computed modulo 2^32; PC=32'hFFFF_FFFC SHALL yield 32'h0000_0000.
REQ-021 When stalled, next_PC SHALL equal PC.
REQ-022 A redirect with im_ready=0, hazard_stall=0, and the state not HALT SHALL latch into pend_valid/pend_target; a later redirect SHALL overwrite the pending one.
REQ-023 pend_valid SHALL clear on the first edge with stall=0; a simultaneous new redirect SHALL win and the pending entry SHALL be discarded.
REQ-024 A redirect during hazard_stall=1 SHALL NOT be latched, because D holds and reasserts it.
REQ-025 Entering HALT SHALL clear pend_valid; a redirect in HALT SHALL be ignored.
REQ-026 halt_req and resume together SHALL resolve as follows: halt wins in RUN/WAIT; the state stays HALT when in HALT.
REQ-027 F_valid SHALL equal (state==RUN or WAIT) & im_ready & !hazard_stall.
REQ-028 fetch_count SHALL increment by 1 on each edge with state in {RUN, WAIT} and stall=0, and SHALL wrap from 16'hFFFF to 0.
REQ-029 All outputs other than fetch_count and state SHALL be combinational from the current state and inputs; there SHALL be no extra latency.

Reset
REQ-030 On reset=0, the block SHALL immediately set state=BOOT, pend_valid=0, pend_target=0, and fetch_count=0.
REQ-031 While reset=0, the outputs SHALL be stall=1, next_PC=RESET_PC, and F_valid=0.
REQ-032 Reset asserted mid-WAIT or mid-HALT SHALL discard all pending state; the first cycle after release SHALL be BOOT.

Verification
REQ-033 Release reset, hold im_ready=1 -> cycle 0 BOOT with next_PC=0x3000; subsequent cycles RUN with next_PC=PC+4; fetch_count=3 after 3 RUN edges.
REQ-034 PC=0x3008, redir_valid=1 to 0x3100, im_ready=0 for 2 cycles -> state=WAIT, stall=1, pend_target=0x3100; when im_ready=1, next_PC=0x3100 and pend_valid clears.
REQ-035 Pending 0x3100, then new redirect 0x3200 in the same cycle im_ready returns -> next_PC=0x3200; no later jump to 0x3100.
REQ-036 hazard_stall=1 with redir_valid=1 for 2 cycles -> next_PC=PC, F_valid=0, pend_valid stays 0, fetch_count unchanged.
REQ-037 halt_req in RUN -> HALT with stall=1; halt_req+resume together -> stays HALT; resume alone -> RUN with next_PC=PC+4.
REQ-038 Reset pulse during WAIT with a pending redirect -> state=BOOT, pend_valid=0, fetch_count=0; first next_PC=0x3000.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch FSM, stall/F_valid generation, next-PC selection
// with a one-entry pending-redirect buffer for redirects that arrive while imem is not ready.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic        im_ready,
    input  logic        hazard_stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] next_PC,
    output logic        stall,
    output logic        F_valid,
    output logic [15:0] fetch_count,
    output logic [1:0]  state
);
    typedef enum logic [1:0] {BOOT, RUN, WAIT, HALT} state_t;
    state_t      cur, nxt;
    logic        pend_valid, pend_valid_nxt;
    logic [31:0] pend_target, pend_target_nxt;
    logic        active;
    assign active = (cur == RUN) || (cur == WAIT);
    assign state  = cur;
    always_comb begin
        nxt = cur == BOOT ? RUN :
              active ? (halt_req ? HALT : im_ready ? RUN : WAIT) :
              (resume && !halt_req) ? RUN : HALT;
        stall   = !reset || cur == HALT || (cur != BOOT && (hazard_stall || !im_ready));
        next_PC = (!reset || cur == BOOT) ? RESET_PC :
                  stall ? PC :
                  redir_valid ? redir_target :
                  pend_valid ? pend_target : PC + 32'd4;
        F_valid = reset && active && im_ready && !hazard_stall;
        pend_valid_nxt  = pend_valid;
        pend_target_nxt = pend_target;
        // D re-presents a redirect it holds under hazard_stall, so only imem stalls are buffered
        if (active && halt_req)
            pend_valid_nxt = 1'b0;
        else if (active && redir_valid && !im_ready && !hazard_stall) begin
            pend_valid_nxt  = 1'b1;
            pend_target_nxt = redir_target;
        end else if (!stall)
            pend_valid_nxt = 1'b0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur         <= BOOT;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            fetch_count <= '0;
        end else begin
            cur         <= nxt;
            pend_valid  <= pend_valid_nxt;
            pend_target <= pend_target_nxt;
            if (active && !stall)
                fetch_count <= fetch_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven check of fetch_sequencer with a scoreboard queue,
// plus a long fetch_count wrap sequence.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PC = '0;
    logic        im_ready = 1'b1;
    logic        hazard_stall = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = '0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] next_PC;
    logic        stall;
    logic        F_valid;
    logic [15:0] fetch_count;
    logic [1:0]  state;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .PC(PC), .im_ready(im_ready),
        .hazard_stall(hazard_stall), .redir_valid(redir_valid),
        .redir_target(redir_target), .halt_req(halt_req), .resume(resume),
        .next_PC(next_PC), .stall(stall), .F_valid(F_valid),
        .fetch_count(fetch_count), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        imr, hz, rv;
        logic [31:0] rt;
        logic        hr, rs;
        logic [31:0] npc;
        logic        stl, fv;
        logic [15:0] cnt;
        logic [1:0]  st;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic rst, logic [31:0] pc, logic imr, logic hz, logic rv,
                                logic [31:0] rt, logic hr, logic rs, logic [31:0] npc,
                                logic stl, logic fv, logic [15:0] cnt, logic [1:0] st);
        vec_t v;
        v.rst = rst; v.pc = pc; v.imr = imr; v.hz = hz; v.rv = rv; v.rt = rt;
        v.hr = hr; v.rs = rs; v.npc = npc; v.stl = stl; v.fv = fv; v.cnt = cnt; v.st = st;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        @(negedge clk);
        reset = v.rst; PC = v.pc; im_ready = v.imr; hazard_stall = v.hz;
        redir_valid = v.rv; redir_target = v.rt; halt_req = v.hr; resume = v.rs;
    endtask

    // outputs are sampled 1 time unit before the next rising edge
    task automatic apply(input vec_t v, input string name);
        vec_t e;
        drive(v);
        sb.push_back(v);
        #4;
        e = sb.pop_front();
        n_vec++;
        if (next_PC !== e.npc || stall !== e.stl || F_valid !== e.fv ||
            fetch_count !== e.cnt || state !== e.st) begin
            n_bad++;
            $display("FAIL %s: got npc=%h stall=%b fv=%b cnt=%h st=%0d, want npc=%h stall=%b fv=%b cnt=%h st=%0d",
                     name, next_PC, stall, F_valid, fetch_count, state,
                     e.npc, e.stl, e.fv, e.cnt, e.st);
        end
    endtask

    initial begin
        //             rst pc            imr hz rv rt          hr rs  npc           stl fv cnt st
        tbl.push_back(mk(0, 32'h0,        1, 0, 0, 32'h0,    0, 0, 32'h3000,     1, 0, 0,  0));
        tbl.push_back(mk(1, 32'h0,        1, 0, 0, 32'h0,    0, 0, 32'h3000,     0, 0, 0,  0));
        tbl.push_back(mk(1, 32'h3000,     1, 0, 0, 32'h0,    0, 0, 32'h3004,     0, 1, 0,  1));
        tbl.push_back(mk(1, 32'h3004,     1, 0, 0, 32'h0,    0, 0, 32'h3008,     0, 1, 1,  1));
        tbl.push_back(mk(1, 32'h3008,     1, 0, 0, 32'h0,    0, 0, 32'h300C,     0, 1, 2,  1));
        tbl.push_back(mk(1, 32'h300C,     1, 0, 0, 32'h0,    0, 0, 32'h3010,     0, 1, 3,  1));
        tbl.push_back(mk(1, 32'h3008,     0, 0, 1, 32'h3100, 0, 0, 32'h3008,     1, 0, 4,  1));
        tbl.push_back(mk(1, 32'h3008,     0, 0, 0, 32'h0,    0, 0, 32'h3008,     1, 0, 4,  2));
        tbl.push_back(mk(1, 32'h3008,     1, 0, 0, 32'h0,    0, 0, 32'h3100,     0, 1, 4,  2));
        tbl.push_back(mk(1, 32'h3100,     1, 0, 0, 32'h0,    0, 0, 32'h3104,     0, 1, 5,  1));
        tbl.push_back(mk(1, 32'h3104,     0, 0, 1, 32'h3100, 0, 0, 32'h3104,     1, 0, 6,  1));
        tbl.push_back(mk(1, 32'h3104,     1, 0, 1, 32'h3200, 0, 0, 32'h3200,     0, 1, 6,  2));
        tbl.push_back(mk(1, 32'h3200,     1, 0, 0, 32'h0,    0, 0, 32'h3204,     0, 1, 7,  1));
        tbl.push_back(mk(1, 32'h3204,     0, 0, 1, 32'h3300, 0, 0, 32'h3204,     1, 0, 8,  1));
        tbl.push_back(mk(1, 32'h3204,     0, 0, 1, 32'h3400, 0, 0, 32'h3204,     1, 0, 8,  2));
        tbl.push_back(mk(1, 32'h3204,     1, 0, 0, 32'h0,    0, 0, 32'h3400,     0, 1, 8,  2));
        tbl.push_back(mk(1, 32'h3400,     1, 0, 0, 32'h0,    0, 0, 32'h3404,     0, 1, 9,  1));
        tbl.push_back(mk(1, 32'h3404,     1, 1, 1, 32'h3500, 0, 0, 32'h3404,     1, 0, 10, 1));
        tbl.push_back(mk(1, 32'h3404,     1, 1, 1, 32'h3500, 0, 0, 32'h3404,     1, 0, 10, 1));
        tbl.push_back(mk(1, 32'h3404,     1, 0, 0, 32'h0,    0, 0, 32'h3408,     0, 1, 10, 1));
        tbl.push_back(mk(1, 32'h3408,     0, 1, 1, 32'h3600, 0, 0, 32'h3408,     1, 0, 11, 1));
        tbl.push_back(mk(1, 32'h3408,     1, 0, 0, 32'h0,    0, 0, 32'h340C,     0, 1, 11, 2));
        tbl.push_back(mk(1, 32'hFFFFFFFC, 1, 0, 0, 32'h0,    0, 0, 32'h0,        0, 1, 12, 1));
        tbl.push_back(mk(1, 32'h0,        1, 0, 0, 32'h0,    1, 0, 32'h4,        0, 1, 13, 1));
        tbl.push_back(mk(1, 32'h4,        1, 0, 1, 32'h3700, 0, 0, 32'h4,        1, 0, 14, 3));
        tbl.push_back(mk(1, 32'h4,        1, 0, 0, 32'h0,    1, 1, 32'h4,        1, 0, 14, 3));
        tbl.push_back(mk(1, 32'h4,        1, 0, 0, 32'h0,    0, 1, 32'h4,        1, 0, 14, 3));
        tbl.push_back(mk(1, 32'h4,        1, 0, 0, 32'h0,    0, 0, 32'h8,        0, 1, 14, 1));
        tbl.push_back(mk(1, 32'h8,        0, 0, 1, 32'h3800, 0, 0, 32'h8,        1, 0, 15, 1));
        tbl.push_back(mk(1, 32'h8,        0, 0, 0, 32'h0,    1, 0, 32'h8,        1, 0, 15, 2));
        tbl.push_back(mk(1, 32'h8,        1, 0, 0, 32'h0,    0, 1, 32'h8,        1, 0, 15, 3));
        tbl.push_back(mk(1, 32'h8,        1, 0, 0, 32'h0,    0, 0, 32'hC,        0, 1, 15, 1));
        tbl.push_back(mk(1, 32'hC,        0, 0, 1, 32'h3900, 0, 0, 32'hC,        1, 0, 16, 1));
        tbl.push_back(mk(0, 32'hC,        1, 0, 0, 32'h0,    0, 0, 32'h3000,     1, 0, 0,  0));
        tbl.push_back(mk(1, 32'hC,        1, 0, 0, 32'h0,    0, 0, 32'h3000,     0, 0, 0,  0));
        tbl.push_back(mk(1, 32'h3000,     1, 0, 0, 32'h0,    0, 0, 32'h3004,     0, 1, 0,  1));
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
        // fetch_count is 1 here; 65534 more RUN advances bring it to 16'hFFFF, then it wraps
        for (int i = 0; i < 65534; i++)
            drive(mk(1, 32'h100, 1, 0, 0, 32'h0, 0, 0, 32'h104, 0, 1, 0, 1));
        apply(mk(1, 32'h100, 1, 0, 0, 32'h0, 0, 0, 32'h104, 0, 1, 16'hFFFF, 1), "cnt_max");
        apply(mk(1, 32'h100, 1, 0, 0, 32'h0, 0, 0, 32'h104, 0, 1, 16'h0000, 1), "cnt_wrap");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
